// File: rtl/lap_stopwatch_pkg.sv
// Shared types and constants for the lap stopwatch core.
package stopwatch_pkg;

    // Operating modes of the stopwatch controller.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2,
        LAP  = 2'd3
    } sw_state_e;

    // Default input clock rate for a board running at 50 MHz.
    localparam int unsigned CLK_HZ_DEFAULT = 32'd50000000;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int unsigned width_of(input int unsigned n);
        int unsigned w;
        if (n > 32'd1) begin
            w = $clog2(n);
        end else begin
            w = 32'd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/lap_stopwatch_if.sv
// Button-pulse inputs and display-side outputs of the lap stopwatch.
interface lap_stopwatch_if #(
    parameter int SEC_W = 10,
    parameter int SUB_W = 4
);
    logic             start_stop;
    logic             lap;
    logic             clear;
    logic [SEC_W-1:0] seconds;
    logic [SUB_W-1:0] sub_sec;
    logic             running;
    logic             lap_active;
    logic             tick;
    logic             wrap;
    logic             overflow;

    // Pulse source (button debouncer side) and display consumer.
    modport master (
        output start_stop, lap, clear,
        input  seconds, sub_sec, running, lap_active, tick, wrap, overflow
    );

    // The stopwatch core itself.
    modport slave (
        input  start_stop, lap, clear,
        output seconds, sub_sec, running, lap_active, tick, wrap, overflow
    );
endinterface

// File: rtl/lap_stopwatch_prescaler.sv
// Divides the system clock down to one sub-second strobe every DIV enabled cycles.
module tick_prescaler
    import stopwatch_pkg::*;
#(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);
    localparam int unsigned       CNT_W = width_of(DIV);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DIV - 32'd1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next prescale count; the strobe fires on the cycle the count rolls over.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (sync_clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Prescale count register; holds its partial interval while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lap_stopwatch.sv
// Stopwatch core: start/stop, lap freeze, clear, bounded seconds with wrap detection.
module lap_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ  = CLK_HZ_DEFAULT,
    parameter int unsigned SUB_DIV = 10,
    parameter int unsigned SEC_MAX = 999
) (
    input  logic            clk,
    input  logic            rst,
    lap_stopwatch_if.slave  bus
);
    localparam int unsigned      DIV      = CLK_HZ / SUB_DIV;
    localparam int unsigned      SEC_W    = width_of(SEC_MAX + 32'd1);
    localparam int unsigned      SUB_W    = width_of(SUB_DIV);
    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_MAX);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_DIV - 32'd1);

    sw_state_e        state_q;
    sw_state_e        state_d;
    logic [SEC_W-1:0] sec_q;
    logic [SUB_W-1:0] sub_q;
    logic [SEC_W-1:0] lap_sec_q;
    logic [SUB_W-1:0] lap_sub_q;
    logic             tick_q;
    logic             wrap_q;
    logic             ovf_q;
    logic             running_q;
    logic             lap_active_q;

    logic             count_en_s;
    logic             pre_clr_s;
    logic             capture_s;
    logic             zero_cnt_s;
    logic             zero_lap_s;
    logic             pulse_tick_s;

    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (count_en_s),
        .sync_clr (pre_clr_s),
        .tick     (pulse_tick_s)
    );

    // Next-state and control strobes; clear beats start_stop beats lap.
    always_comb begin
        state_d    = state_q;
        pre_clr_s  = 1'b0;
        capture_s  = 1'b0;
        zero_cnt_s = 1'b0;
        zero_lap_s = 1'b0;
        if (bus.clear) begin
            state_d    = IDLE;
            pre_clr_s  = 1'b1;
            zero_cnt_s = 1'b1;
            zero_lap_s = 1'b1;
        end else if (bus.start_stop) begin
            case (state_q)
                IDLE: begin
                    state_d   = RUN;
                    pre_clr_s = 1'b1;
                end
                RUN:     state_d = STOP;
                STOP:    state_d = RUN;
                LAP:     state_d = STOP;
                default: state_d = IDLE;
            endcase
        end else if (bus.lap) begin
            case (state_q)
                IDLE:    state_d = IDLE;
                RUN: begin
                    state_d   = LAP;
                    capture_s = 1'b1;
                end
                LAP:     state_d = RUN;
                STOP: begin
                    state_d    = IDLE;
                    pre_clr_s  = 1'b1;
                    zero_cnt_s = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Prescaler runs only while live and no stop/clear is being accepted this edge.
    always_comb begin
        count_en_s = 1'b0;
        if (!bus.clear && !bus.start_stop && ((state_q == RUN) || (state_q == LAP))) begin
            count_en_s = 1'b1;
        end else begin
            count_en_s = 1'b0;
        end
    end

    // State register with status flags decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            running_q    <= 1'b0;
            lap_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            running_q    <= (state_d == RUN) || (state_d == LAP);
            lap_active_q <= (state_d == LAP);
        end
    end

    // Sub-second / seconds counters with wrap pulse and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec_q  <= '0;
            sub_q  <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            tick_q <= pulse_tick_s;
            wrap_q <= 1'b0;
            if (zero_cnt_s) begin
                sec_q <= '0;
                sub_q <= '0;
                ovf_q <= 1'b0;
            end else if (pulse_tick_s) begin
                if (sub_q == SUB_LAST) begin
                    sub_q <= '0;
                    if (sec_q == SEC_LAST) begin
                        sec_q  <= '0;
                        wrap_q <= 1'b1;
                        ovf_q  <= 1'b1;
                    end else begin
                        sec_q <= sec_q + SEC_W'(1);
                    end
                end else begin
                    sub_q <= sub_q + SUB_W'(1);
                end
            end else begin
                sec_q <= sec_q;
                sub_q <= sub_q;
            end
        end
    end

    // Lap registers take the pre-increment count on the accepting edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lap_sec_q <= '0;
            lap_sub_q <= '0;
        end else if (zero_lap_s) begin
            lap_sec_q <= '0;
            lap_sub_q <= '0;
        end else if (capture_s) begin
            lap_sec_q <= sec_q;
            lap_sub_q <= sub_q;
        end else begin
            lap_sec_q <= lap_sec_q;
            lap_sub_q <= lap_sub_q;
        end
    end

    // Display mux: frozen lap value in LAP, live count otherwise.
    always_comb begin
        if (state_q == LAP) begin
            bus.seconds = lap_sec_q;
            bus.sub_sec = lap_sub_q;
        end else begin
            bus.seconds = sec_q;
            bus.sub_sec = sub_q;
        end
    end

    assign bus.running    = running_q;
    assign bus.lap_active = lap_active_q;
    assign bus.tick       = tick_q;
    assign bus.wrap       = wrap_q;
    assign bus.overflow   = ovf_q;

endmodule
